// File: rtl/line_fill_memory.sv
// Backing-store responder for a cache miss/refill port: line-burst reads and
// write-back bursts against word-addressed storage, with a fixed response latency.
module line_fill_memory #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int OFFSET_WIDTH   = 2,
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter int LATENCY        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_done,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy
);

    localparam int LINE_W = MEM_DEPTH_LOG2 - OFFSET_WIDTH;
    localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT, WR_ACK
    } state_e;

    state_e                  state_q, state_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [OFFSET_WIDTH-1:0] beat_q, beat_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic                    req_ready_q, req_ready_d;
    logic                    wr_ready_q, wr_ready_d;
    logic                    wr_done_q, wr_done_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_last_q, rd_last_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    busy_q, busy_d;

    logic [DATA_WIDTH-1:0]   mem_q [0:(1<<MEM_DEPTH_LOG2)-1];
    logic                    mem_we;
    logic                    load_rd;
    logic [OFFSET_WIDTH-1:0] rd_idx;

    // Only the line index inside the stored depth is used; the rest aliases.
    logic unused_addr;
    assign unused_addr = ^req_addr;

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        rd_valid_d = 1'b0;
        rd_last_d = 1'b0;
        rd_data_d = rd_data_q;
        mem_we    = 1'b0;
        load_rd   = 1'b0;
        rd_idx    = beat_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    line_d = req_addr[MEM_DEPTH_LOG2-1:OFFSET_WIDTH];
                    beat_d = '0;
                    if (req_write) begin
                        state_d = WR_BURST;
                    end else if (LATENCY == 0) begin
                        state_d = RD_BURST;
                        load_rd = 1'b1;
                        rd_idx  = '0;
                    end else begin
                        state_d = RD_WAIT;
                        wait_d  = WAIT_W'(LATENCY - 1);
                    end
                end
            end
            RD_WAIT: begin
                if (wait_q == '0) begin
                    state_d = RD_BURST;
                    load_rd = 1'b1;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            RD_BURST: begin
                if (rd_last_q) state_d = IDLE;
                else           load_rd = 1'b1;
            end
            WR_BURST: begin
                if (wr_valid && wr_ready_q) begin
                    mem_we = !rst;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == '1) begin
                        state_d = (LATENCY == 0) ? WR_ACK : WR_WAIT;
                        wait_d  = WAIT_W'(LATENCY - 1);
                    end
                end
            end
            WR_WAIT: begin
                if (wait_q == '0) state_d = WR_ACK;
                else              wait_d  = wait_q - 1'b1;
            end
            WR_ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The first beat is registered on the edge that enters RD_BURST,
        // so the line index may be the one being latched right now.
        if (load_rd) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[{line_d, rd_idx}];
            rd_last_d  = (rd_idx == '1);
            beat_d     = rd_idx + 1'b1;
        end
        req_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == WR_BURST);
        wr_done_d   = (state_d == WR_ACK);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            line_q      <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            wr_done_q   <= wr_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[{line_q, beat_q}] <= wr_data;
    end

    assign req_ready = req_ready_q;
    assign wr_ready  = wr_ready_q;
    assign wr_done   = wr_done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_line_fill_memory.sv
// Directed bench for line_fill_memory: one instance at LATENCY=4, one at LATENCY=0,
// selected by use0; inputs change and outputs are sampled on the falling edge.
module tb_line_fill_memory;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        use0 = 1'b0;
  int          lat = 4;

  int n_checks = 0;
  int n_errors = 0;

  logic        rr4, wrr4, wd4, rdv4, rdl4, b4;
  logic        rr0, wrr0, wd0, rdv0, rdl0, b0;
  logic [31:0] rdd4, rdd0;
  logic        rv4, rv0;
  logic        req_ready, wr_ready, wr_done, rd_valid, rd_last, busy;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  assign rv4 = req_valid & ~use0;
  assign rv0 = req_valid & use0;

  line_fill_memory #(.LATENCY(4)) dut (
    .clk(clk), .rst(rst), .req_valid(rv4), .req_ready(rr4), .req_write(req_write),
    .req_addr(req_addr), .wr_valid(wr_valid), .wr_ready(wrr4), .wr_data(wr_data),
    .wr_done(wd4), .rd_valid(rdv4), .rd_data(rdd4), .rd_last(rdl4), .busy(b4)
  );

  line_fill_memory #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_write(req_write),
    .req_addr(req_addr), .wr_valid(wr_valid), .wr_ready(wrr0), .wr_data(wr_data),
    .wr_done(wd0), .rd_valid(rdv0), .rd_data(rdd0), .rd_last(rdl0), .busy(b0)
  );

  assign req_ready = use0 ? rr0  : rr4;
  assign wr_ready  = use0 ? wrr0 : wrr4;
  assign wr_done   = use0 ? wd0  : wd4;
  assign rd_valid  = use0 ? rdv0 : rdv4;
  assign rd_data   = use0 ? rdd0 : rdd4;
  assign rd_last   = use0 ? rdl0 : rdl4;
  assign busy      = use0 ? b0   : b4;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with the DUT idle.
  task automatic do_write(input logic [15:0] addr, input logic [127:0] line, input bit gap);
    int cnt;
    int pulses;
    int first;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    cnt = 0;
    while (!req_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("wr req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    check("wr_ready in burst", wr_ready, 1);
    check("busy in burst", busy, 1);
    for (int i = 0; i < 4; i++) begin
      if (gap && i == 1) begin
        wr_valid = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("wr_ready during gap", wr_ready, 1);
          check("wr_done during gap", wr_done, 0);
        end
      end
      wr_valid = 1'b1;
      wr_data  = line[32*i +: 32];
      @(negedge clk);
      if (i < 3) check("wr_done early", wr_done, 0);
    end
    wr_valid = 1'b0;
    pulses = 0;
    first  = -1;
    for (int k = 1; k <= lat + 3; k++) begin
      if (k > 1) @(negedge clk);
      if (wr_done) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check("wr_done pulses", pulses, 1);
    check("wr_done delay", first, lat + 1);
    check("req_ready after write", req_ready, 1);
  endtask

  // Called at a falling edge. hold keeps req_valid high (address switched to
  // next_addr); abort pulses rst after that many read beats.
  task automatic do_read(input logic [15:0] addr, input logic [127:0] line,
                         input bit hold, input logic [15:0] next_addr, input int abort);
    int cnt;
    int idx;
    bit vexp;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    cnt = 0;
    while (!req_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("rd req_ready", req_ready, 1);
    for (int k = 1; k <= lat + 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) req_addr = next_addr;
        else      req_valid = 1'b0;
      end
      idx  = k - lat - 1;
      vexp = (k >= lat + 1) && (k <= lat + 4);
      if (k == lat + 5) begin
        check("rd_valid after burst", rd_valid, 0);
        check("req_ready after burst", req_ready, 1);
      end else begin
        check("rd_valid timing", rd_valid, vexp);
        if (vexp) begin
          check("rd_data beat", rd_data, line[32*idx +: 32]);
          check("rd_last beat", rd_last, (idx == 3));
        end else begin
          check("req_ready in wait", req_ready, 0);
        end
      end
      if (abort != 0 && k == lat + abort) begin
        rst = 1'b1;
        @(negedge clk);
        check("rd_valid after abort", rd_valid, 0);
        check("rd_last after abort", rd_last, 0);
        check("busy after abort", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("req_ready after abort", req_ready, 1);
        return;
      end
    end
  endtask

  initial begin
    logic [127:0] line_a;
    logic [127:0] line_b;
    line_a = {32'h33333333, 32'h22222222, 32'h11111111, 32'hAABBCCDD};
    line_b = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", req_ready, 0);
    check("reset wr_ready", wr_ready, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_last", rd_last, 0);
    check("reset wr_done", wr_done, 0);
    check("reset busy", busy, 0);
    check("reset rd_data", rd_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("req_ready after release", req_ready, 1);
    check("dut0 req_ready after release", rr0, 1);

    // LATENCY=4 instance.
    do_write(16'h0010, line_a, 1'b0);
    do_read(16'h0013, line_a, 1'b0, 16'h0000, 0);
    do_write(16'h0020, line_b, 1'b1);
    do_read(16'h0020, line_b, 1'b0, 16'h0000, 0);
    do_read(16'h0010, line_a, 1'b1, 16'h1010, 0);
    do_read(16'h1010, line_a, 1'b0, 16'h0000, 0);
    do_read(16'h0022, line_b, 1'b0, 16'h0000, 2);
    // Storage survives the aborted read's reset.
    do_read(16'h0021, line_b, 1'b0, 16'h0000, 0);

    // LATENCY=0 instance.
    use0 = 1'b1;
    lat  = 0;
    do_write(16'h0010, line_a, 1'b0);
    do_read(16'h0013, line_a, 1'b0, 16'h0000, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
